rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 a_valid  input  1  requester A (ALU writeback) offers a write.
REQ-004 a_ready  output  1  A's write is accepted on this edge when a_valid=1.
REQ-005 a_reg  input  5  A destination register.
REQ-006 a_data  input  64  A write data.
REQ-007 b_valid, b_ready, b_reg, b_data  same widths and meanings as REQ-003..006, for requester B (load writeback).
REQ-008 RegWrite  output  1  registered write enable to the register file.
REQ-009 WriteRegister  output  5  registered write target.
REQ-010 WriteData  output  64  registered write data.
REQ-011 chk_reg  input  5  register queried for a pending write.
REQ-012 chk_pending  output  1  combinational; 1 = a write to chk_reg is accepted but not yet presented to the register file.

Function
REQ-013 Each requester SHALL own a one-entry buffer (full flag, reg, data).
REQ-014 Acceptance for A SHALL occur at a rising edge with a_valid=1 and a_ready=1; B likewise.
REQ-015 a_ready SHALL equal (not a_full) OR grant_a in the same cycle, forced to 0 while rst=1; b_ready likewise.
REQ-016 An accepted write to register 31 (hardwired zero) SHALL be discarded: buffer not loaded, never presented on RegWrite.
REQ-017 Each cycle the arbiter SHALL grant at most one full buffer; one full buffer -> grant it.
REQ-018 Both full, different registers -> grant the requester not granted last (rr pointer); first contention after reset grants A.
REQ-019 Both full, same register -> grant the older entry; entries loaded on the same edge count A as older.
REQ-020 Age bit: A loaded while B stays full -> B older; B loaded while A stays full -> A older; both loaded on one edge -> A older.
REQ-021 On the edge after a grant: RegWrite=1, WriteRegister/WriteData = granted entry; granted buffer empties unless refilled on that edge.
REQ-022 No grant in a cycle -> RegWrite=0 on the next edge; WriteRegister/WriteData hold their previous values.
REQ-023 Latency: accepted at edge N with an empty arbiter -> RegWrite=1 after edge N+1; register file captures at edge N+2.
REQ-024 Throughput: one write per cycle sustained; each requester sustains one per cycle when the other is idle.
REQ-025 A buffer SHALL be refilled on the same edge that it is granted.
REQ-026 chk_pending=1 iff chk_reg matches a full buffer's reg, or RegWrite=1 and WriteRegister=chk_reg; chk_reg=31 -> 0.
REQ-027 rr pointer SHALL update only on a contended grant (both buffers full).

Reset
REQ-028 rst=1 at an edge SHALL clear both buffers, RegWrite=0, WriteRegister=0, WriteData=0, age bit = A older, rr = A wins next contention.
REQ-029 Reset mid-operation SHALL discard all buffered writes without presenting them; the output stage is cleared on the same edge.
REQ-030 While rst=1: a_ready=b_ready=0 and chk_pending=0.

Verification
REQ-031 A only: a_reg=5, a_data=0x1111 accepted at edge 1 -> RegWrite=1, WriteRegister=5, WriteData=0x1111 after edge 2; RegWrite=0 after edge 3.
REQ-032 A (reg 3) and B (reg 4) accepted on the same edge -> A presented first, B next cycle; repeat the pair -> B first (round-robin alternation).
REQ-033 Same register: B (reg 7, 0xB) accepted at edge 1, A (reg 7, 0xA) at edge 2 while B is blocked -> 0xB written before 0xA; same-edge tie -> A then B.
REQ-034 A writes register 31 -> a_ready=1, RegWrite stays 0, chk_pending(31)=0.
REQ-035 Both buffers full, rst pulsed for one cycle -> RegWrite=0, buffers empty; no buffered write ever appears.
REQ-036 chk_reg=9: 1 from the cycle after B's reg-9 acceptance through the cycle with RegWrite=1, WriteRegister=9; 0 after.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the two writeback requesters, the register-file write port and the
// pending-write query used between the arbiter and its environment.
interface rf_write_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [63:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [63:0] b_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  chk_reg;
  logic        chk_pending;

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    output chk_reg,
    input  a_ready, b_ready,
    input  RegWrite, WriteRegister, WriteData,
    input  chk_pending
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    input  chk_reg,
    output a_ready, b_ready,
    output RegWrite, WriteRegister, WriteData,
    output chk_pending
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: one-entry buffer per requester,
// round-robin on contention, oldest-first on same-register conflicts.
module rf_write_arbiter (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic        a_full;
  logic [4:0]  a_reg_q;
  logic [63:0] a_data_q;
  logic        b_full;
  logic [4:0]  b_reg_q;
  logic [63:0] b_data_q;
  logic        age_a_older;
  logic        rr_b_next;

  logic        reg_write_q;
  logic [4:0]  write_reg_q;
  logic [63:0] write_data_q;

  logic grant_a;
  logic grant_b;
  logic a_accept;
  logic b_accept;
  logic a_load;
  logic b_load;
  logic pending_hit;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      if (a_reg_q == b_reg_q)
        grant_a = age_a_older;
      else
        grant_a = ~rr_b_next;
      grant_b = ~grant_a;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  assign bus.a_ready = ~rst & (~a_full | grant_a);
  assign bus.b_ready = ~rst & (~b_full | grant_b);

  // Writes to the hardwired-zero register are acknowledged but never buffered.
  assign a_accept = bus.a_valid & bus.a_ready;
  assign b_accept = bus.b_valid & bus.b_ready;
  assign a_load   = a_accept & (bus.a_reg != ZERO_REG);
  assign b_load   = b_accept & (bus.b_reg != ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full   <= 1'b0;
      a_reg_q  <= '0;
      a_data_q <= '0;
      b_full   <= 1'b0;
      b_reg_q  <= '0;
      b_data_q <= '0;
    end else begin
      if (a_load) begin
        a_full   <= 1'b1;
        a_reg_q  <= bus.a_reg;
        a_data_q <= bus.a_data;
      end else if (grant_a) begin
        a_full <= 1'b0;
      end
      if (b_load) begin
        b_full   <= 1'b1;
        b_reg_q  <= bus.b_reg;
        b_data_q <= bus.b_data;
      end else if (grant_b) begin
        b_full <= 1'b0;
      end
    end
  end

  // The newest load makes the other buffer the older one; a joint load favours A.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_a_older <= 1'b1;
      rr_b_next   <= 1'b0;
    end else begin
      if (a_load && b_load)
        age_a_older <= 1'b1;
      else if (a_load)
        age_a_older <= 1'b0;
      else if (b_load)
        age_a_older <= 1'b1;
      if (a_full && b_full)
        rr_b_next <= grant_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= grant_a | grant_b;
      if (grant_a) begin
        write_reg_q  <= a_reg_q;
        write_data_q <= a_data_q;
      end else if (grant_b) begin
        write_reg_q  <= b_reg_q;
        write_data_q <= b_data_q;
      end
    end
  end

  assign bus.RegWrite      = reg_write_q;
  assign bus.WriteRegister = write_reg_q;
  assign bus.WriteData     = write_data_q;

  assign pending_hit = (a_full && (a_reg_q == bus.chk_reg)) ||
                       (b_full && (b_reg_q == bus.chk_reg)) ||
                       (reg_write_q && (write_reg_q == bus.chk_reg));

  assign bus.chk_pending = ~rst & (bus.chk_reg != ZERO_REG) & pending_hit;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply requester inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                               input logic bv, input logic [4:0] br, input logic [63:0] bd);
    bus.a_valid = av;
    bus.a_reg   = ar;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_reg   = br;
    bus.b_data  = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
  endtask

  task automatic expectWrite(input string tag, input logic [4:0] r, input logic [63:0] d);
    checkOutput({tag, "_we"}, 64'(bus.RegWrite), 64'd1);
    checkOutput({tag, "_reg"}, 64'(bus.WriteRegister), 64'(r));
    checkOutput({tag, "_data"}, bus.WriteData, d);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.chk_reg = 5'd5;
    bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
    @(posedge clk); #1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    @(posedge clk); #1;

    // Reset state and ready/pending suppression while reset is held
    checkOutput("rst_we", 64'(bus.RegWrite), 64'd0);
    checkOutput("rst_reg", 64'(bus.WriteRegister), 64'd0);
    checkOutput("rst_data", bus.WriteData, 64'd0);
    checkOutput("rst_a_ready", 64'(bus.a_ready), 64'd0);
    checkOutput("rst_b_ready", 64'(bus.b_ready), 64'd0);
    checkOutput("rst_pending", 64'(bus.chk_pending), 64'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("idle_a_ready", 64'(bus.a_ready), 64'd1);
    checkOutput("idle_b_ready", 64'(bus.b_ready), 64'd1);

    // Single A write: latency and hold
    applyStimulus(1'b1, 5'd5, 64'h1111, 1'b0, 5'd0, 64'h0);
    checkOutput("a1_we_early", 64'(bus.RegWrite), 64'd0);
    checkOutput("a1_pend_buf", 64'(bus.chk_pending), 64'd1);
    idle();
    expectWrite("a1", 5'd5, 64'h1111);
    checkOutput("a1_pend_out", 64'(bus.chk_pending), 64'd1);
    idle();
    checkOutput("a1_we_off", 64'(bus.RegWrite), 64'd0);
    checkOutput("a1_reg_hold", 64'(bus.WriteRegister), 64'd5);
    checkOutput("a1_data_hold", bus.WriteData, 64'h1111);
    checkOutput("a1_pend_off", 64'(bus.chk_pending), 64'd0);

    // Contention, different registers: A first, then alternation
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    idle();
    expectWrite("rr1_first", 5'd3, 64'h33);
    idle();
    expectWrite("rr1_second", 5'd4, 64'h44);
    idle();
    checkOutput("rr1_we_off", 64'(bus.RegWrite), 64'd0);
    applyStimulus(1'b1, 5'd3, 64'h35, 1'b1, 5'd4, 64'h46);
    idle();
    expectWrite("rr2_first", 5'd4, 64'h46);
    idle();
    expectWrite("rr2_second", 5'd3, 64'h35);
    idle();

    // Same register: older B entry must drain before the newer A entry
    applyStimulus(1'b1, 5'd10, 64'hAA, 1'b1, 5'd7, 64'hB);
    bus.a_valid = 1'b1; bus.a_reg = 5'd7; bus.a_data = 64'hA;
    bus.b_valid = 1'b0;
    #1;
    checkOutput("age_b_ready", 64'(bus.b_ready), 64'd0);
    checkOutput("age_a_ready", 64'(bus.a_ready), 64'd1);
    applyStimulus(1'b1, 5'd7, 64'hA, 1'b0, 5'd0, 64'h0);
    expectWrite("age_w0", 5'd10, 64'hAA);
    idle();
    expectWrite("age_w1", 5'd7, 64'hB);
    idle();
    expectWrite("age_w2", 5'd7, 64'hA);
    idle();
    // Same-edge tie goes to A
    applyStimulus(1'b1, 5'd7, 64'hA2, 1'b1, 5'd7, 64'hB2);
    idle();
    expectWrite("tie_w1", 5'd7, 64'hA2);
    idle();
    expectWrite("tie_w2", 5'd7, 64'hB2);
    idle();

    // Register 31 is acknowledged but discarded
    bus.chk_reg = 5'd31;
    bus.a_valid = 1'b1; bus.a_reg = 5'd31; bus.a_data = 64'hDEAD;
    #1;
    checkOutput("z31_ready", 64'(bus.a_ready), 64'd1);
    applyStimulus(1'b1, 5'd31, 64'hDEAD, 1'b0, 5'd0, 64'h0);
    checkOutput("z31_pend", 64'(bus.chk_pending), 64'd0);
    idle();
    checkOutput("z31_we1", 64'(bus.RegWrite), 64'd0);
    idle();
    checkOutput("z31_we2", 64'(bus.RegWrite), 64'd0);

    // Sustained A throughput, one write per cycle
    applyStimulus(1'b1, 5'd11, 64'h111, 1'b0, 5'd0, 64'h0);
    checkOutput("tp_ready", 64'(bus.a_ready), 64'd1);
    applyStimulus(1'b1, 5'd12, 64'h112, 1'b0, 5'd0, 64'h0);
    expectWrite("tp_w1", 5'd11, 64'h111);
    applyStimulus(1'b1, 5'd13, 64'h113, 1'b0, 5'd0, 64'h0);
    expectWrite("tp_w2", 5'd12, 64'h112);
    idle();
    expectWrite("tp_w3", 5'd13, 64'h113);
    idle();

    // Mid-operation reset flushes both buffers and the output stage
    applyStimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    rst = 1'b1;
    idle();
    checkOutput("mrst_we", 64'(bus.RegWrite), 64'd0);
    checkOutput("mrst_reg", 64'(bus.WriteRegister), 64'd0);
    checkOutput("mrst_data", bus.WriteData, 64'd0);
    rst = 1'b0;
    bus.chk_reg = 5'd1;
    #1;
    checkOutput("mrst_pend", 64'(bus.chk_pending), 64'd0);
    checkOutput("mrst_b_ready", 64'(bus.b_ready), 64'd1);
    idle();
    checkOutput("mrst_we1", 64'(bus.RegWrite), 64'd0);
    idle();
    checkOutput("mrst_we2", 64'(bus.RegWrite), 64'd0);

    // Pending window for a B write to register 9
    bus.chk_reg = 5'd9;
    bus.b_valid = 1'b1; bus.b_reg = 5'd9; bus.b_data = 64'h99;
    #1;
    checkOutput("p9_before", 64'(bus.chk_pending), 64'd0);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h99);
    checkOutput("p9_buf", 64'(bus.chk_pending), 64'd1);
    idle();
    expectWrite("p9_w", 5'd9, 64'h99);
    checkOutput("p9_out", 64'(bus.chk_pending), 64'd1);
    idle();
    checkOutput("p9_after", 64'(bus.chk_pending), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
